// File: rtl/wave_pkg.sv
// wave_pkg: shared constants for the waveform-generator configuration slave.
//   - opcode encodings carried in cmd[7:6] of an SPI command frame
//   - waveform select encodings driven on waveform_o
//   - readback ID constant returned for the no-op opcode
//   - FSM state encoding of wave_config_spi
package wave_pkg;

  localparam logic [1:0] OP_PHASE     = 2'b00;
  localparam logic [1:0] OP_AMPLITUDE = 2'b01;
  localparam logic [1:0] OP_MODE      = 2'b10;
  localparam logic [1:0] OP_NOP       = 2'b11;

  localparam logic [1:0] WF_SINE      = 2'b00;
  localparam logic [1:0] WF_SQUARE    = 2'b01;
  localparam logic [1:0] WF_SAWTOOTH  = 2'b10;
  localparam logic [1:0] WF_TRIANGLE  = 2'b11;

  localparam logic [7:0] READBACK_ID  = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SHIFT   = 2'b01,
    ST_EXEC    = 2'b10,
    ST_WAIT_CS = 2'b11
  } state_e;

endpackage

// File: rtl/wave_config_spi_if.sv
// wave_config_spi_if: configuration port of the waveform generator.
//   data_o                 signed phase/amplitude value, held between writes
//   set_phase_strobe_o     one-cycle write strobe for the phase register
//   set_amplitude_strobe_o one-cycle write strobe for the amplitude register
//   waveform_o             waveform select (sine/square/sawtooth/triangle)
//   enable_o               generator enable
// Handshake: there is no ready. A strobe is a single-cycle valid; the consumer
// must take data_o in the same clk_i cycle the strobe is high. The two strobes
// are never high together. waveform_o/enable_o are levels, no strobe.
// Modports: master = configuration source (wave_config_spi), slave = generator.
interface wave_config_spi_if #(
  parameter int N_FRAC = 7
) ();
  logic signed [N_FRAC:0] data_o;
  logic                   set_phase_strobe_o;
  logic                   set_amplitude_strobe_o;
  logic [1:0]             waveform_o;
  logic                   enable_o;

  modport master (
    output data_o, set_phase_strobe_o, set_amplitude_strobe_o, waveform_o, enable_o
  );

  modport slave (
    input data_o, set_phase_strobe_o, set_amplitude_strobe_o, waveform_o, enable_o
  );
endinterface

// File: rtl/spi_input_sync.sv
// spi_input_sync: two-flop synchroniser plus one history flop for one
// asynchronous SPI line, with edge detection in the clk_i domain.
//   clk_i, rst_i  system clock, synchronous active-high reset
//   d_i           asynchronous input line
//   level_o       synchronised level (second flop)
//   rise_o        one-cycle pulse on a synchronised 0->1 transition
//   fall_o        one-cycle pulse on a synchronised 1->0 transition
// RST_VAL is the level all three flops take in reset, so no edge is seen
// while leaving reset unless the line really moves.
module spi_input_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      s3_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;
  assign fall_o  = ~s2_q & s3_q;
endmodule

// File: rtl/wave_config_spi.sv
// wave_config_spi: SPI mode-0 slave turning 16-bit command frames
// (command byte, payload byte, MSB first) into configuration writes for the
// waveform generator.
//   clk_i, rst_i   system clock (>= 4x SCLK), synchronous active-high reset
//   sclk_i, cs_n_i, mosi_i  asynchronous SPI inputs
//   miso_o         readback serial output (0 unless readback is built in)
//   cfg            configuration port, master side (see wave_config_spi_if)
//   state_o        current FSM state, for observation
// Optional feature: define WAVE_CONFIG_READBACK_EN to add phase/amplitude
// shadow registers and shift a readback byte out on miso_o during byte 1.
module wave_config_spi
  import wave_pkg::*;
#(
  parameter int N_FRAC = 7
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sclk_i,
  input  logic                cs_n_i,
  input  logic                mosi_i,
  output logic                miso_o,
  wave_config_spi_if.master   cfg,
  output state_e              state_o
);
  localparam int W = N_FRAC + 1;

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_n_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic cs_active;

  spi_input_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(sclk_i),
    .level_o(sclk_level), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  // cs_n resets to "selected" so a frame already running at reset release
  // is not mistaken for a fresh one; armed_q then waits for a real high.
  spi_input_sync #(.RST_VAL(1'b0)) u_sync_cs (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(cs_n_i),
    .level_o(cs_n_level), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_input_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(mosi_i),
    .level_o(mosi_level), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign cs_active = ~cs_n_level;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [1:0]      op_q, op_d;
  logic            armed_q, armed_d;
  logic [W-1:0]    data_q, data_d;
  logic            ps_q, ps_d;
  logic            as_q, as_d;
  logic [1:0]      wf_q, wf_d;
  logic            en_q, en_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      shift_q <= 8'd0;
      op_q    <= OP_NOP;
      armed_q <= 1'b0;
      data_q  <= '0;
      ps_q    <= 1'b0;
      as_q    <= 1'b0;
      wf_q    <= WF_SINE;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      op_q    <= op_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      ps_q    <= ps_d;
      as_q    <= as_d;
      wf_q    <= wf_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    op_d    = op_q;
    armed_d = armed_q | ~cs_active;
    data_d  = data_q;
    ps_d    = 1'b0;
    as_d    = 1'b0;
    wf_d    = wf_q;
    en_d    = en_q;

    case (state_q)
      ST_IDLE: begin
        if (cs_active && armed_q) begin
          cnt_d   = 4'd0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!cs_active) begin
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          // Only the payload byte is kept in the shifter; the opcode is
          // lifted out of it when the command byte completes.
          shift_d = {shift_q[6:0], mosi_level};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) op_d = shift_q[6:5];
          if (cnt_q == 4'd15) state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_PHASE: begin
            data_d = W'($signed(shift_q));
            ps_d   = 1'b1;
          end
          OP_AMPLITUDE: begin
            data_d = W'($signed(shift_q));
            as_d   = 1'b1;
          end
          OP_MODE: begin
            wf_d = shift_q[1:0];
            en_d = shift_q[2];
          end
          default: ;
        endcase
        state_d = ST_WAIT_CS;
      end
      ST_WAIT_CS: begin
        if (!cs_active) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cfg.data_o                 = data_q;
  assign cfg.set_phase_strobe_o     = ps_q;
  assign cfg.set_amplitude_strobe_o = as_q;
  assign cfg.waveform_o             = wf_q;
  assign cfg.enable_o               = en_q;
  assign state_o                    = state_q;

`ifdef WAVE_CONFIG_READBACK_EN
  logic [W-1:0] phase_sh_q, amp_sh_q;
  logic [7:0]   rb_q, rb_sel;
  logic         miso_q;
  logic         rb_load, rb_shift, exec;

  assign exec     = (state_q == ST_EXEC);
  assign rb_load  = (state_q == ST_SHIFT) && cs_active && sclk_rise && (cnt_q == 4'd7);
  assign rb_shift = (state_q == ST_SHIFT) && cs_active && sclk_fall && cnt_q[3];

  // Opcode bits sit in shift_q[6:5] on the rise that completes the command.
  always_comb begin
    rb_sel = 8'h00;
    case (shift_q[6:5])
      OP_PHASE:     rb_sel = 8'(phase_sh_q);
      OP_AMPLITUDE: rb_sel = 8'(amp_sh_q);
      OP_MODE:      rb_sel = {5'b0, en_q, wf_q};
      default:      rb_sel = READBACK_ID;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_sh_q <= '0;
      amp_sh_q   <= '0;
      rb_q       <= 8'h00;
      miso_q     <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) miso_q <= 1'b0;
      if (rb_load) begin
        rb_q <= rb_sel;
      end else if (rb_shift) begin
        miso_q <= rb_q[7];
        rb_q   <= {rb_q[6:0], 1'b0};
      end
      if (exec && op_q == OP_PHASE)     phase_sh_q <= W'($signed(shift_q));
      if (exec && op_q == OP_AMPLITUDE) amp_sh_q   <= W'($signed(shift_q));
    end
  end

  assign miso_o = miso_q;
`else
  assign miso_o = 1'b0;
`endif

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_level, sclk_fall, cs_rise, cs_fall, mosi_rise, mosi_fall};

endmodule

// File: tb/tb_wave_config_spi.sv
module tb_wave_config_spi;
  import wave_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  logic   sclk, cs_n, mosi;
  logic   miso;
  state_e state;
  int     cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wave_config_spi_if #(.N_FRAC(7)) cfg_if ();

  wave_config_spi #(.N_FRAC(7)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .sclk_i  (sclk),
    .cs_n_i  (cs_n),
    .mosi_i  (mosi),
    .miso_o  (miso),
    .cfg     (cfg_if),
    .state_o (state)
  );

  int checks   = 0;
  int failures = 0;

  // expected word: {phase_stb, amp_stb, data[7:0], waveform[1:0], enable}
  logic [12:0] exp_q[$];
  int          exp_cyc_q[$];

  logic [7:0] m_data;
  logic [1:0] m_wf;
  logic       m_en;

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, 32'($unsigned(cfg_if.data_o)), 32'h0);
    check({tag, "_pstb"}, 32'(cfg_if.set_phase_strobe_o), 32'h0);
    check({tag, "_astb"}, 32'(cfg_if.set_amplitude_strobe_o), 32'h0);
    check({tag, "_wf"}, 32'(cfg_if.waveform_o), 32'(WF_SINE));
    check({tag, "_en"}, 32'(cfg_if.enable_o), 32'h0);
    check({tag, "_miso"}, 32'(miso), 32'h0);
    check({tag, "_state"}, 32'(state), 32'(ST_IDLE));
  endtask

  // Expected effect of one accepted frame, visible 4 cycles after the
  // 16th SCLK rise is driven (3 edges after it is first sampled).
  task automatic model_frame(input logic [7:0] cmd, input logic [7:0] pay, input int at);
    case (cmd[7:6])
      2'b00: begin
        m_data = pay;
        exp_q.push_back({2'b10, pay, m_wf, m_en});
        exp_cyc_q.push_back(at);
      end
      2'b01: begin
        m_data = pay;
        exp_q.push_back({2'b01, pay, m_wf, m_en});
        exp_cyc_q.push_back(at);
      end
      2'b10: begin
        if (pay[1:0] != m_wf || pay[2] != m_en) begin
          m_wf = pay[1:0];
          m_en = pay[2];
          exp_q.push_back({2'b00, m_data, m_wf, m_en});
          exp_cyc_q.push_back(at);
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  // Shifts the low n bits of v, MSB first; half periods of 4 clk cycles.
  // rb collects miso sampled before rises 9..16.
  task automatic spi_bits(input logic [31:0] v, input int n, input bit use_model,
                          output logic [7:0] rb);
    logic [31:0] t;
    rb = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = v[n-1-i];
      wait_clk(4);
      if (i >= 8 && i < 16) rb = {rb[6:0], miso};
      sclk = 1'b1;
      if (i == 15 && use_model) begin
        t = v >> (n - 16);
        model_frame(t[15:8], t[7:0], cyc + 4);
      end
      wait_clk(4);
      sclk = 1'b0;
    end
    mosi = 1'b0;
  endtask

  task automatic spi_frame(input logic [15:0] f, output logic [7:0] rb);
    cs_n = 1'b0;
    wait_clk(4);
    spi_bits({16'h0, f}, 16, 1'b1, rb);
    cs_n = 1'b1;
    wait_clk(6);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [7:0] p_data = 8'h00;
  logic [1:0] p_wf   = 2'b00;
  logic       p_en   = 1'b0;
  logic       miso_seen = 1'b0;

  always @(negedge clk) begin
    logic [12:0] act, e;
    int          ec;
    act = {cfg_if.set_phase_strobe_o, cfg_if.set_amplitude_strobe_o,
           cfg_if.data_o, cfg_if.waveform_o, cfg_if.enable_o};
    if (!rst && (cfg_if.set_phase_strobe_o || cfg_if.set_amplitude_strobe_o ||
                 cfg_if.data_o != p_data || cfg_if.waveform_o != p_wf ||
                 cfg_if.enable_o != p_en)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%h@%0d expected=none", act, cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if (act !== e || cyc != ec) begin
          failures++;
          $display("FAIL cfg_write actual=%h@%0d expected=%h@%0d", act, cyc, e, ec);
        end
      end
    end
    p_data = cfg_if.data_o;
    p_wf   = cfg_if.waveform_o;
    p_en   = cfg_if.enable_o;
`ifndef WAVE_CONFIG_READBACK_EN
    if (miso !== 1'b0) miso_seen = 1'b1;
`endif
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rb;
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    m_data = 8'h00; m_wf = 2'b00; m_en = 1'b0;
    wait_clk(3);
    check_reset_outputs("por");
    rst = 1'b0;
    wait_clk(5);

    // phase write 0x40
    spi_frame(16'h0040, rb);
    // amplitude write -128, then mode: triangle + enable
    spi_frame(16'h4080, rb);
    spi_frame(16'h8007, rb);
    check("mode_keeps_data", 32'($unsigned(cfg_if.data_o)), 32'h80);

    // abort after 10 bits of 0x00,0x7F, then a normal phase write
    cs_n = 1'b0;
    wait_clk(4);
    spi_bits(32'h0000_0001, 10, 1'b0, rb);
    cs_n = 1'b1;
    wait_clk(6);
    check("abort_data", 32'($unsigned(cfg_if.data_o)), 32'h80);
    spi_frame(16'h0011, rb);

    // 20 pulses in one CS window; only the first 16 bits count
    cs_n = 1'b0;
    wait_clk(4);
    spi_bits({12'h0, 16'h4022, 4'hB}, 20, 1'b1, rb);
    cs_n = 1'b1;
    wait_clk(6);

    // reset after 12 bits of 0x80,0x06; remaining 4 bits must do nothing
    cs_n = 1'b0;
    wait_clk(4);
    spi_bits(32'h0000_0800, 12, 1'b0, rb);
    rst = 1'b1;
    wait_clk(2);
    check_reset_outputs("midrst");
    m_data = 8'h00; m_wf = 2'b00; m_en = 1'b0;
    rst = 1'b0;
    wait_clk(2);
    spi_bits(32'h0000_0006, 4, 1'b0, rb);
    cs_n = 1'b1;
    wait_clk(6);
    check("postrst_wf", 32'(cfg_if.waveform_o), 32'(WF_SINE));
    check("postrst_state", 32'(state), 32'(ST_IDLE));

    // normal traffic after reset
    spi_frame(16'h0033, rb);
    spi_frame(16'h8005, rb);
    spi_frame(16'hC055, rb);
    spi_frame(16'h8002, rb);
    spi_frame(16'h4000, rb);

`ifdef WAVE_CONFIG_READBACK_EN
    spi_frame(16'h005A, rb);
    spi_frame(16'h0000, rb);
    check("rb_phase", 32'(rb), 32'h5A);
    spi_frame(16'hC000, rb);
    check("rb_id", 32'(rb), 32'(READBACK_ID));
`endif

    wait_clk(10);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
`ifndef WAVE_CONFIG_READBACK_EN
    check("miso_tied", 32'(miso_seen), 32'h0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    checks++;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wave_config_spi.md
# wave_config_spi

SPI-mode-0 slave that turns 16-bit serial command frames from an external controller into the parallel configuration writes the waveform generator consumes. Outputs drive the generator's configuration port directly:
- shared signed data byte
- one-cycle phase and amplitude set strobes
- waveform select
- enable

It is the initiator side of the generator's configuration interface and sits between the chip's input pins and the generator.

## Interface
Parameters:
- N_FRAC, 7, fractional bits; data width is N_FRAC+1.

Ports:
- clk_i  input  1  system clock; must run at least 4x SCLK.
- rst_i  input  1  synchronous, active-high reset.
- sclk_i  input  1  SPI clock, asynchronous to clk_i, idle low.
- cs_n_i  input  1  SPI chip select, active low, asynchronous.
- mosi_i  input  1  SPI serial data in, MSB first.
- miso_o  output  1  SPI serial data out (readback only).
- data_o  output  N_FRAC+1  signed value for phase/amplitude writes.
- set_phase_strobe_o  output  1  one-cycle phase write strobe.
- set_amplitude_strobe_o  output  1  one-cycle amplitude write strobe.
- waveform_o  output  2  waveform select: 00 sine, 01 square/pulse, 10 sawtooth, 11 triangle.
- enable_o  output  1  generator enable.

## Operation
- Input synchronisation:
  - sclk_i, cs_n_i and mosi_i each pass through 2 flops plus one history flop.
  - sclk_rise = s2 & ~s3; sclk_fall = ~s2 & s3; cs_active = ~s2(cs).
- Frame: 16 bits, MSB first.
  - Byte 0 is the command; cmd[7:6] is the opcode and cmd[5:0] is ignored.
  - Byte 1 is the payload.
- Opcodes:
  - 00: phase write. data_o <= payload; set_phase_strobe_o pulses.
  - 01: amplitude write. data_o <= payload; set_amplitude_strobe_o pulses.
  - 10: mode write. waveform_o <= payload[1:0]; enable_o <= payload[2]; no strobe.
  - 11: no-op. No output change.
- FSM:
  - IDLE: wait for cs_active; clear the bit counter, go to SHIFT.
  - SHIFT: on each sclk_rise, shift in mosi and increment the 4-bit counter. The rise that completes bit 16 goes to EXEC.
  - EXEC: one cycle. Apply the decoded write and register the strobe. Go to WAIT_CS.
  - WAIT_CS: ignore all SCLK activity until ~cs_active, then go to IDLE.
- cs_n deasserting in SHIFT aborts the frame: no output change, return to IDLE.
- Strobes are never both high, and are high for exactly one clk_i cycle per accepted frame.
- data_o holds its value between writes. A mode write leaves data_o unchanged.
- Reset, including mid-frame:
  - FSM goes to IDLE and any partial frame is discarded.
  - data_o = 0, both strobes = 0, waveform_o = 00, enable_o = 0, miso_o = 0.
  - A frame already in progress when rst_i releases is ignored until cs_n is seen high.

## Timing
- Latency: the 16th SCLK rise at the pin is first sampled on clk_i edge E. Then:
  - The shift register completes on E+2.
  - EXEC runs during the cycle after E+2.
  - Strobe, data_o, waveform_o and enable_o update on edge E+3, and the strobe drops on E+4.
- Back-to-back frames need cs_n high for at least 3 clk_i cycles between them. Frames are never queued.
- SCLK high and low times must each be at least 2 clk_i periods.

## Configuration
- WAVE_CONFIG_READBACK_EN defined:
  - Shadow registers hold the last written phase and amplitude.
  - During byte 1, miso_o shifts out, MSB first, a value selected by the opcode:
    - 00: phase shadow.
    - 01: amplitude shadow.
    - 10: {5'b0, enable_o, waveform_o}.
    - 11: ID constant 8'hA5.
  - Readback timing:
    - The readback byte is loaded on the sclk_rise that completes bit 8.
    - MSB is driven on the following sclk_fall, with one bit per subsequent sclk_fall.
    - miso_o returns to 0 in IDLE.
  - The write still takes effect at EXEC, so the value read out is the pre-write value.
- Not defined: miso_o is tied 0 and no shadow registers exist.

## Structure
- Shared package wave_pkg:
  - opcode constants OP_PHASE, OP_AMPLITUDE, OP_MODE, OP_NOP;
  - waveform encodings WF_SINE, WF_SQUARE, WF_SAWTOOTH, WF_TRIANGLE;
  - READBACK_ID = 8'hA5;
  - FSM state encoding.
- Sub-module spi_input_sync: 2-flop synchroniser plus history flop per line, with rise/fall outputs. Instantiated once per SPI input.

## Test plan
- Frame 0x00,0x40 (phase write) -> data_o = 0x40 and set_phase_strobe_o high for exactly 1 cycle, 3 edges after the 16th SCLK rise is sampled; amplitude strobe stays 0.
- Frame 0x40,0x80 -> data_o = 0x80 (-128) with a single set_amplitude_strobe_o pulse; a following frame 0x80,0x07 -> waveform_o = 11, enable_o = 1, no strobe, data_o still 0x80.
- cs_n raised after 10 bits of 0x00,0x7F -> no strobe and data_o unchanged; the next full frame 0x00,0x11 is accepted normally.
- 20 SCLK pulses in one CS window with 0x40,0x22 in the first 16 bits -> exactly one amplitude write with data_o = 0x22; extra bits ignored.
- rst_i asserted after 12 bits of a frame -> all outputs at reset values; the remaining bits produce no write; the next frame after a cs_n high works.
- With WAVE_CONFIG_READBACK_EN: phase write 0x5A, then frame 0x00,xx -> miso_o returns 0x5A during byte 1; frame 0xC0,xx -> miso_o returns 0xA5.
